// File: rtl/data_stack_if.sv
// Operand-stack port bundle: operation/data from the controller, stack view back to it.
interface data_stack_if #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 16
);
    localparam int DW = $clog2(DEPTH + 1);

    logic [2:0]       stackOP;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] top;
    logic [WIDTH-1:0] second;
    logic [DW-1:0]    depth;
    logic             overflow;
    logic             underflow;

    // Controller side: issues operations, observes the stack.
    modport master (
        output stackOP, din,
        input  top, second, depth, overflow, underflow
    );

    // Stack side: executes operations, presents entries 0/1 and status.
    modport slave (
        input  stackOP, din,
        output top, second, depth, overflow, underflow
    );
endinterface

// File: rtl/data_stack.sv
// Register-based operand stack. Entry 0 is the top of stack and feeds the ALU A
// operand, entry 1 feeds the B operand, so both are live the cycle after an op.
// Vacated entries are always zeroed so top/second read 0 when not valid.
// Illegal operations (push when full, short pops/swaps) leave the stack intact
// and set a sticky flag that only reset clears.
module data_stack #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 16
) (
    input logic         CLK,
    input logic         reset,
    data_stack_if.slave bus
);
    localparam int DW = $clog2(DEPTH + 1);
    localparam logic [DW-1:0] FULL = DW'(DEPTH);

    typedef enum logic [2:0] {
        OP_NONE   = 3'd0,
        OP_PUSH   = 3'd1,
        OP_POPREP = 3'd2,
        OP_POP    = 3'd3,
        OP_POP2   = 3'd4,
        OP_SWAP   = 3'd5
    } op_e;

    logic [WIDTH-1:0] entry_q [DEPTH];
    logic [WIDTH-1:0] entry_d [DEPTH];
    logic [DW-1:0]    depth_q, depth_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    // Next-state computation for every opcode, including the rejected cases.
    always_comb begin
        // NOTE: every output of this block is given its hold value first, so no path
        // leaves a signal unassigned and no latch is inferred.
        entry_d     = entry_q;
        depth_d     = depth_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        case (bus.stackOP)
            OP_PUSH: begin
                if (depth_q == FULL) begin
                    overflow_d = 1'b1;
                end else begin
                    for (int i = DEPTH - 1; i > 0; i--) begin
                        entry_d[i] = entry_q[i-1];
                    end
                    entry_d[0] = bus.din;
                    depth_d    = depth_q + DW'(1);
                end
            end
            OP_POPREP: begin
                // Binary-op result replaces the two operands: A/B consumed, result pushed.
                if (depth_q < DW'(2)) begin
                    underflow_d = 1'b1;
                end else begin
                    entry_d[0] = bus.din;
                    for (int i = 1; i < DEPTH - 1; i++) begin
                        entry_d[i] = entry_q[i+1];
                    end
                    entry_d[DEPTH-1] = '0;
                    depth_d          = depth_q - DW'(1);
                end
            end
            OP_POP: begin
                if (depth_q == '0) begin
                    underflow_d = 1'b1;
                end else begin
                    for (int i = 0; i < DEPTH - 1; i++) begin
                        entry_d[i] = entry_q[i+1];
                    end
                    entry_d[DEPTH-1] = '0;
                    depth_d          = depth_q - DW'(1);
                end
            end
            OP_POP2: begin
                if (depth_q < DW'(2)) begin
                    underflow_d = 1'b1;
                end else begin
                    for (int i = 0; i < DEPTH - 2; i++) begin
                        entry_d[i] = entry_q[i+2];
                    end
                    entry_d[DEPTH-2] = '0;
                    entry_d[DEPTH-1] = '0;
                    depth_d          = depth_q - DW'(2);
                end
            end
            OP_SWAP: begin
                if (depth_q < DW'(2)) begin
                    underflow_d = 1'b1;
                end else begin
                    entry_d[0] = entry_q[1];
                    entry_d[1] = entry_q[0];
                end
            end
            default: begin
                // NONE and the unused codes 6/7 hold all state.
            end
        endcase
    end

    // State register; synchronous reset wins over any op on the same edge.
    always_ff @(posedge CLK) begin
        if (reset) begin
            // NOTE: the entries are flops, not RAM, and are all cleared because the
            // stack contract is that unused slots (and thus top/second) read zero.
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            depth_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            entry_q     <= entry_d;
            depth_q     <= depth_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.top       = entry_q[0];
    assign bus.second    = entry_q[1];
    assign bus.depth     = depth_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;

endmodule

// File: doc/data_stack.md
DATA_STACK -- requirements
Module: data_stack

Interface
REQ-001 SHALL provide parameter DEPTH, default 32, meaning number of stack entries.
REQ-002 SHALL provide parameter WIDTH, default 16, meaning bits per entry.
REQ-003 SHALL provide port CLK  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL provide port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL provide port stackOP  input  3  operation code:
- 0 NONE
- 1 PUSH
- 2 POPANDREPLACE
- 3 POP
- 4 POP2
- 5 SWAP
- 6 and 7 treated as NONE.
REQ-006 SHALL provide port din  input  WIDTH  value written by PUSH and POPANDREPLACE (mux output selected by stackControl).
REQ-007 SHALL provide port top  output  WIDTH  entry 0, the ALU A operand.
REQ-008 SHALL provide port second  output  WIDTH  entry 1, the ALU B operand.
REQ-009 SHALL provide port depth  output  clog2(DEPTH+1)  number of valid entries, 0..DEPTH.
REQ-010 SHALL provide port overflow  output  1  sticky, set by PUSH when full.
REQ-011 SHALL provide port underflow  output  1  sticky, set by any op needing more entries than are valid.

Function
REQ-012 SHALL hold entries 0..DEPTH-1 as registers; top and second SHALL be driven directly from entries 0 and 1, so they are valid in the same cycle the state changes, with no extra latency.
REQ-013 SHALL clear every entry at or beyond depth to 0 whenever an operation vacates it; top reads 0 when depth=0, and second reads 0 when depth<2.
REQ-014 PUSH with depth<DEPTH SHALL:
- shift entries down one position (entry DEPTH-1 discarded);
- load entry 0 with din;
- increment depth by 1.
REQ-015 POPANDREPLACE with depth>=2 SHALL:
- load entry 0 with din;
- shift entries 2..DEPTH-1 up one position;
- clear entry DEPTH-1;
- decrement depth by 1.
REQ-016 POP with depth>=1 SHALL shift all entries up one position, clear entry DEPTH-1, and decrement depth by 1.
REQ-017 POP2 with depth>=2 SHALL shift all entries up two positions, clear the last two entries, and decrement depth by 2.
REQ-018 SWAP with depth>=2 SHALL exchange entries 0 and 1; depth is unchanged.
REQ-019 NONE SHALL leave all state unchanged.
REQ-020 PUSH at depth=DEPTH SHALL leave entries and depth unchanged and set overflow.
REQ-021 POP at depth=0, and POPANDREPLACE, POP2 or SWAP at depth<2, SHALL leave entries and depth unchanged and set underflow.
REQ-022 overflow and underflow SHALL clear only on reset; later legal operations execute normally while a flag remains set.
REQ-023 din SHALL be sampled only on the edge on which PUSH or POPANDREPLACE executes.
REQ-024 depth arithmetic SHALL never wrap: it stays within 0..DEPTH under any op sequence.

Reset
REQ-025 reset=1 at a rising edge SHALL set all entries to 0, depth to 0, overflow to 0 and underflow to 0.
REQ-026 reset SHALL take priority over any stackOP presented on the same edge; that op has no effect.
REQ-027 During reset, top=0, second=0 and depth=0 SHALL hold from the first edge with reset=1 until the first edge after reset deasserts.

Verification
REQ-028 Basic push/add: PUSH din=5, PUSH din=7, then POPANDREPLACE din=12 -> top=12, second=0, depth=1, no flags set.
REQ-029 Swap/pop2: PUSH 1, 2, 3, then SWAP -> top=2, second=3, depth=3; then POP2 -> top=1, second=0, depth=1.
REQ-030 Full boundary: 32 PUSHes of values 1..32 -> depth=32, top=32, second=31; a 33rd PUSH of 99 -> top=32, depth=32, overflow=1; then POP -> top=31, depth=31, overflow still 1.
REQ-031 Empty boundary: from reset, POP -> underflow=1, depth=0; then PUSH 4 and SWAP -> top=4, depth=1, underflow=1; then POP2 -> unchanged.
REQ-032 Reset mid-operation: PUSH 8, PUSH 9, then assert reset together with PUSH 10 -> top=0, second=0, depth=0, both flags 0 on the next cycle.
REQ-033 Illegal codes: depth=2 with top=6, second=5, apply stackOP=6 then stackOP=7 -> state unchanged, no flags set.
